// File: rtl/pwm_decoder_pkg.sv
// Shared types and constants for the PWM decoder.
package pwm_decoder_pkg;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2
  } state_e;

  localparam int SYNC_STAGES = 2;

  // Saturation value of the period counter; reaching it means no edge was seen.
  function automatic longint unsigned timeout_val(input int cnt_width);
    return (64'd1 << cnt_width) - 64'd1;
  endfunction

endpackage

// File: rtl/pwm_duty_div.sv
// Restoring divider, one quotient bit per cycle; quotient is presented
// combinationally in the final iteration cycle alongside done.
module pwm_duty_div
  import pwm_decoder_pkg::*;
#(
  parameter int CNT_WIDTH  = 16,
  parameter int DUTY_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [CNT_WIDTH+DUTY_WIDTH-1:0] dividend,
  input  logic [CNT_WIDTH-1:0]          divisor,
  output logic                          busy,
  output logic                          done,
  output logic [DUTY_WIDTH-1:0]         quotient
);

  localparam int IT_W = $clog2(DUTY_WIDTH + 1);

  logic [CNT_WIDTH-1:0]  r_rem;
  logic [CNT_WIDTH-1:0]  r_dsr;
  logic [DUTY_WIDTH-1:0] r_q;
  logic [IT_W-1:0]       r_it;
  logic                  r_busy;

  logic [CNT_WIDTH:0]    w_sh;
  logic [CNT_WIDTH:0]    w_diff;
  logic                  w_ge;
  logic [CNT_WIDTH-1:0]  w_rem_nxt;
  logic [DUTY_WIDTH-1:0] w_q_nxt;

  // Upper dividend part is below the divisor, so only DUTY_WIDTH steps are needed
  // and the remainder always fits CNT_WIDTH bits.
  assign w_sh      = {r_rem, r_q[DUTY_WIDTH-1]};
  assign w_diff    = w_sh - {1'b0, r_dsr};
  assign w_ge      = (w_sh >= {1'b0, r_dsr});
  assign w_rem_nxt = w_ge ? w_diff[CNT_WIDTH-1:0] : w_sh[CNT_WIDTH-1:0];
  assign w_q_nxt   = {r_q[DUTY_WIDTH-2:0], w_ge};

  assign busy     = r_busy;
  assign done     = r_busy & (r_it == IT_W'(1));
  assign quotient = w_q_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_dsr  <= '0;
      r_q    <= '0;
      r_it   <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_rem  <= dividend[CNT_WIDTH+DUTY_WIDTH-1:DUTY_WIDTH];
      r_q    <= dividend[DUTY_WIDTH-1:0];
      r_dsr  <= divisor;
      r_it   <= IT_W'(DUTY_WIDTH);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem <= w_rem_nxt;
      r_q   <= w_q_nxt;
      r_it  <= r_it - IT_W'(1);
      if (r_it == IT_W'(1)) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/pwm_decoder.sv
// Measures period and high time of an asynchronous PWM input and reports a
// normalised duty value, with overrun and no-edge timeout signalling.
module pwm_decoder
  import pwm_decoder_pkg::*;
#(
  parameter int CNT_WIDTH  = 16,
  parameter int DUTY_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pwm_in,
  output logic [CNT_WIDTH-1:0]  period,
  output logic [CNT_WIDTH-1:0]  high_time,
  output logic [DUTY_WIDTH-1:0] duty,
  output logic                  valid,
  output logic                  overrun,
  output logic                  timeout
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(timeout_val(CNT_WIDTH));

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   r_hcap;
  logic [CNT_WIDTH-1:0]   r_div_h;
  logic [CNT_WIDTH-1:0]   r_div_p;
  logic [CNT_WIDTH-1:0]   r_period;
  logic [CNT_WIDTH-1:0]   r_high;
  logic [DUTY_WIDTH-1:0]  r_duty;
  logic                   r_valid;
  logic                   r_ovr;
  logic                   r_timeout;
  state_e                 r_state;

  state_e                 w_state_nxt;
  logic                   w_sync;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_start;
  logic                   w_ovr;
  logic                   w_hcap_ld;
  logic                   w_to_fire;
  logic                   w_div_busy;
  logic                   w_div_done;
  logic                   w_div_idle;
  logic [DUTY_WIDTH-1:0]  w_quot;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = w_sync & ~r_prev;
  assign w_fall = ~w_sync & r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      r_prev <= w_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                 r_cnt <= '0;
    else if (w_rise)         r_cnt <= CNT_WIDTH'(1);
    else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
  end

  // A divider finishing this cycle is free for a new sample.
  assign w_div_idle = ~w_div_busy | w_div_done;
  // A busy divider defers the timeout; the saturated counter keeps it pending.
  assign w_to_fire  = (r_cnt == CNT_MAX) & ~r_timeout & ~w_rise & ~w_div_busy;

  always_ff @(posedge clk) begin
    if (rst) r_state <= WAIT_RISE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_ovr       = 1'b0;
    w_hcap_ld   = 1'b0;
    case (r_state)
      WAIT_RISE: if (w_rise) w_state_nxt = HIGH;
      HIGH: if (w_fall) begin
        w_hcap_ld   = 1'b1;
        w_state_nxt = LOW;
      end
      LOW: if (w_rise) begin
        w_state_nxt = HIGH;
        if (w_div_idle) w_start = 1'b1;
        else            w_ovr   = 1'b1;
      end
      default: w_state_nxt = WAIT_RISE;
    endcase
    if (w_to_fire) w_state_nxt = WAIT_RISE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcap  <= '0;
      r_div_h <= '0;
      r_div_p <= '0;
    end else begin
      if (w_hcap_ld) r_hcap <= r_cnt;
      if (w_start) begin
        r_div_h <= r_hcap;
        r_div_p <= r_cnt;
      end
    end
  end

  pwm_duty_div #(
    .CNT_WIDTH (CNT_WIDTH),
    .DUTY_WIDTH(DUTY_WIDTH)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (w_start),
    .dividend({r_hcap, DUTY_WIDTH'(0)}),
    .divisor (r_cnt),
    .busy    (w_div_busy),
    .done    (w_div_done),
    .quotient(w_quot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_period  <= '0;
      r_high    <= '0;
      r_duty    <= '0;
      r_valid   <= 1'b0;
      r_ovr     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ovr   <= w_ovr;
      if (w_div_done) begin
        r_valid  <= 1'b1;
        r_period <= r_div_p;
        r_high   <= r_div_h;
        r_duty   <= w_quot;
      end else if (w_to_fire) begin
        r_valid  <= 1'b1;
        r_period <= '0;
        r_high   <= '0;
        r_duty   <= {DUTY_WIDTH{w_sync}};
      end
      if (w_to_fire)   r_timeout <= 1'b1;
      else if (w_rise) r_timeout <= 1'b0;
    end
  end

  assign period    = r_period;
  assign high_time = r_high;
  assign duty      = r_duty;
  assign valid     = r_valid;
  assign overrun   = r_ovr;
  assign timeout   = r_timeout;

endmodule

// File: doc/pwm_decoder.md
Name: pwm_decoder

Overview:
Measures an incoming PWM waveform, such as a loopback of the buzzer line or an external PWM source. Reports period, high time and normalised duty cycle.
Counterpart to the team's buzzer PWM generator: the generator turns a duty value into a waveform, and this block turns a waveform back into a duty value.
Used for self-test of the audio path and as a generic PWM input for control registers.

Parameters:
CNT_WIDTH, 16, width of period/high-time counters; also sets the timeout at 2^CNT_WIDTH-1 cycles without an edge
DUTY_WIDTH, 8, width of the duty result; duty = floor(high_time * 2^DUTY_WIDTH / period)

Ports:
clk  input  1  system clock; the block's single clock domain
rst  input  1  synchronous, active-high reset, sampled on rising clk
pwm_in  input  1  asynchronous PWM input
period  output  CNT_WIDTH  last measured period in clk cycles, rise to rise
high_time  output  CNT_WIDTH  last measured high time in clk cycles, rise to fall
duty  output  DUTY_WIDTH  normalised duty of the last period
valid  output  1  one-cycle pulse when period/high_time/duty update
overrun  output  1  one-cycle pulse when a completed period is dropped
timeout  output  1  level; no edge seen for 2^CNT_WIDTH-1 cycles

Behaviour:
- Reset: all outputs 0; synchroniser flops 0; counter 0; FSM in WAIT_RISE; divider idle.
- Input conditioning: 2-flop synchroniser, then a previous-value register.
  - rise event = sync high and prev low; fall event = sync low and prev high.
  - All timing below is counted in event cycles; the fixed 2-cycle input latency cancels out.
- Counter: loads 1 on each rise event; otherwise increments, saturating at 2^CNT_WIDTH-1.
- For rise at cycle t0, fall at t1, next rise at t2: high_time = t1-t0 and period = t2-t0.
- FSM states:
  - WAIT_RISE: ignore falls; on rise go to HIGH and load the counter. This discards partial periods after reset or timeout.
  - HIGH: on fall, latch the counter value as high_cap and go to LOW.
  - LOW: on rise, capture period_cap = counter and reload the counter to 1. If the divider is idle, start it with (high_cap, period_cap); otherwise pulse overrun for 1 cycle and drop the sample. Go to HIGH in both cases.
- Divider (pwm_duty_div):
  - Restoring division of high_cap<<DUTY_WIDTH by period_cap, one quotient bit per cycle.
  - Start cycle plus DUTY_WIDTH iterations; result appears on the outputs DUTY_WIDTH+1 cycles after the rise event, together with the valid pulse.
  - period, high_time and duty update atomically in the valid cycle and hold until the next update.
- Width rules:
  - high_time < period always, so the quotient fits DUTY_WIDTH bits.
  - Minimum legal period is 2 cycles; period_cap is never 0.
  - Dividend width is CNT_WIDTH+DUTY_WIDTH.
- Timeout: the counter reaching 2^CNT_WIDTH-1 in HIGH, LOW or WAIT_RISE triggers it.
  - Divider idle: assert timeout (level), pulse valid, set period=0, high_time=0, duty = all ones if sync high else 0. Go to WAIT_RISE.
  - Divider busy: defer that update until the divider finishes.
  - A timeout already asserted does not re-fire.
  - timeout clears on the next rise event.
- Simultaneous events:
  - A rise event in the same cycle the divider finishes counts as idle: the new sample starts, with no overrun.
  - The finishing result is still published that cycle.
- rst mid-measurement or mid-division aborts everything; no valid pulse is emitted for the aborted sample.

Decomposition:
- Package pwm_decoder_pkg holds:
  - FSM state enum (WAIT_RISE, HIGH, LOW)
  - SYNC_STAGES = 2
  - a function computing the timeout value from CNT_WIDTH
- Sub-module pwm_duty_div(clk, rst, start, dividend, divisor, busy, done, quotient) is a natural split. It is reusable by future APU blocks.

Test Plan:
- rst, then pwm_in high 64 / low 192 repeated -> first valid after the second rise; period=256, high_time=64, duty=64; valid exactly 9 cycles after each rise event.
- 50% square, period 20 -> period=20, high_time=10, duty=128; no overrun.
- Period 4 (high 2), DUTY_WIDTH=8 -> divider busy at the next rise; overrun pulses on every alternate rise; the published samples still show duty=128.
- CNT_WIDTH=8 build, pwm_in held high after one valid measurement -> timeout at counter 255; valid with duty=255, period=0. Then a low/high toggle -> timeout clears on the rise, and normal measurement resumes after a full period.
- Same build, pwm_in held low -> timeout with duty=0.
- Assert rst for 1 cycle mid-division -> all outputs 0 next cycle; no valid for the aborted sample; the following measurement is correct.
